mem_arbiter: RTL and testbench

- Two-master to one-slave request arbiter between the CPU core's IFU and LSU ports and the single unified memory/MMIO port.
- Serialises fetch and load/store requests onto one memory port, with round-robin tie-break and one outstanding transaction.
- Returns each response to the master that issued it.
- Bounds every transaction with a timeout; on expiry the requester gets an error word.

---
 rtl/mem_arbiter.sv | 101 ++++++++++
 tb/tb_mem_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin IFU/LSU arbiter onto one memory port, one outstanding
// transaction at a time, each bounded by a WAIT-state timeout.
module mem_arbiter #(
  parameter int          TIMEOUT  = 256,
  parameter logic [31:0] ERR_DATA = 32'hdeadbeef
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_ifu_reqValid,
  input  logic [31:0] io_ifu_addr,
  output logic        io_ifu_respValid,
  output logic [31:0] io_ifu_rdata,
  input  logic        io_lsu_reqValid,
  input  logic [31:0] io_lsu_addr,
  input  logic        io_lsu_wen,
  input  logic [31:0] io_lsu_wdata,
  input  logic [3:0]  io_lsu_wmask,
  input  logic [1:0]  io_lsu_size,
  output logic        io_lsu_respValid,
  output logic [31:0] io_lsu_rdata,
  output logic        io_mem_reqValid,
  output logic [31:0] io_mem_addr,
  output logic        io_mem_wen,
  output logic [31:0] io_mem_wdata,
  output logic [3:0]  io_mem_wmask,
  output logic [1:0]  io_mem_size,
  input  logic        io_mem_respValid,
  input  logic [31:0] io_mem_rdata,
  output logic        io_busy,
  output logic        io_timeout,
  output logic        io_stray
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_grant_lsu;
  logic        r_last_lsu;
  logic        w_pick_lsu;
  logic        w_done;
  logic [31:0] w_rdata;
  // On a tie the master that was not served last wins.
  assign w_pick_lsu = io_lsu_reqValid && (!io_ifu_reqValid || !r_last_lsu);
  // A real response on the limit cycle beats the timeout.
  assign w_done     = io_mem_respValid || r_cnt == 16'(TIMEOUT - 1);
  assign w_rdata    = io_mem_respValid ? io_mem_rdata : ERR_DATA;
  assign io_busy    = r_state != S_IDLE;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_grant_lsu      <= 1'b0;
      r_last_lsu       <= 1'b1;
      io_mem_reqValid  <= 1'b0;
      io_mem_addr      <= '0;
      io_mem_wen       <= 1'b0;
      io_mem_wdata     <= '0;
      io_mem_wmask     <= '0;
      io_mem_size      <= '0;
      io_ifu_respValid <= 1'b0;
      io_ifu_rdata     <= '0;
      io_lsu_respValid <= 1'b0;
      io_lsu_rdata     <= '0;
      io_timeout       <= 1'b0;
      io_stray         <= 1'b0;
    end else begin
      io_mem_reqValid  <= 1'b0;
      io_ifu_respValid <= 1'b0;
      io_lsu_respValid <= 1'b0;
      io_timeout       <= 1'b0;
      io_stray         <= io_mem_respValid && r_state != S_WAIT;
      case (r_state)
        S_IDLE: if (io_ifu_reqValid || io_lsu_reqValid) begin
          r_grant_lsu     <= w_pick_lsu;
          io_mem_addr     <= w_pick_lsu ? io_lsu_addr : io_ifu_addr;
          io_mem_wen      <= w_pick_lsu && io_lsu_wen;
          io_mem_wdata    <= w_pick_lsu ? io_lsu_wdata : '0;
          io_mem_wmask    <= w_pick_lsu ? io_lsu_wmask : '0;
          io_mem_size     <= w_pick_lsu ? io_lsu_size : 2'b10;
          io_mem_reqValid <= 1'b1;
          r_state         <= S_ISSUE;
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: if (w_done) begin
          io_ifu_respValid <= !r_grant_lsu;
          io_lsu_respValid <= r_grant_lsu;
          if (r_grant_lsu) io_lsu_rdata <= w_rdata;
          else io_ifu_rdata <= w_rdata;
          io_timeout <= !io_mem_respValid;
          r_state    <= S_RESP;
        end else r_cnt <= r_cnt + 16'd1;
        S_RESP: begin
          r_last_lsu <= r_grant_lsu;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus random traffic, checked every cycle against a transaction-level model.
module tb_mem_arbiter;
  localparam int          T   = 8;
  localparam logic [31:0] ERR = 32'hdeadbeef;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ifu_req = 1'b0;
  logic [31:0] ifu_addr = '0;
  logic        lsu_req = 1'b0;
  logic [31:0] lsu_addr = '0;
  logic        lsu_wen = 1'b0;
  logic [31:0] lsu_wdata = '0;
  logic [3:0]  lsu_wmask = '0;
  logic [1:0]  lsu_size = '0;
  logic        mem_rv = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        io_ifu_respValid, io_lsu_respValid, io_mem_reqValid, io_mem_wen;
  logic        io_busy, io_timeout, io_stray;
  logic [31:0] io_ifu_rdata, io_lsu_rdata, io_mem_addr, io_mem_wdata;
  logic [3:0]  io_mem_wmask;
  logic [1:0]  io_mem_size;
  int checks = 0, errors = 0, cyc = 0;
  int iss, resp_cyc, idle_from, due, lat, last, g, force_lat = 1;
  bit in_txn, exp_to, stray_held, auto_m, drain;
  logic [31:0] m_addr, m_wdata, exp_data, exp_ifu_rd, exp_lsu_rd;
  logic        m_wen;
  logic [3:0]  m_wmask;
  logic [1:0]  m_size;
  mem_arbiter #(.TIMEOUT(T), .ERR_DATA(ERR)) dut (
    .clock(clock), .reset(reset),
    .io_ifu_reqValid(ifu_req), .io_ifu_addr(ifu_addr),
    .io_ifu_respValid(io_ifu_respValid), .io_ifu_rdata(io_ifu_rdata),
    .io_lsu_reqValid(lsu_req), .io_lsu_addr(lsu_addr), .io_lsu_wen(lsu_wen),
    .io_lsu_wdata(lsu_wdata), .io_lsu_wmask(lsu_wmask), .io_lsu_size(lsu_size),
    .io_lsu_respValid(io_lsu_respValid), .io_lsu_rdata(io_lsu_rdata),
    .io_mem_reqValid(io_mem_reqValid), .io_mem_addr(io_mem_addr), .io_mem_wen(io_mem_wen),
    .io_mem_wdata(io_mem_wdata), .io_mem_wmask(io_mem_wmask), .io_mem_size(io_mem_size),
    .io_mem_respValid(mem_rv), .io_mem_rdata(mem_rdata),
    .io_busy(io_busy), .io_timeout(io_timeout), .io_stray(io_stray)
  );
  always #5 clock = ~clock;
  function automatic logic [31:0] mem_val(logic [31:0] a);
    return a == 32'h30000000 ? 32'h00100073 : (a ^ 32'ha5a50f0f) + 32'h1357;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    ifu_req = 1'b0;
    lsu_req = 1'b0;
    mem_rv = 1'b0;
    @(posedge clock); #1; cyc++;
    reset = 1'b0;
    in_txn = 0; last = 1; due = -1; stray_held = 0; idle_from = cyc;
    exp_ifu_rd = '0; exp_lsu_rd = '0;
    chk("rst_mem_reqValid", io_mem_reqValid, 0);
    chk("rst_mem_addr", io_mem_addr, 0);
    chk("rst_mem_wen", io_mem_wen, 0);
    chk("rst_mem_wdata", io_mem_wdata, 0);
    chk("rst_mem_wmask", io_mem_wmask, 0);
    chk("rst_mem_size", io_mem_size, 0);
    chk("rst_ifu_respValid", io_ifu_respValid, 0);
    chk("rst_lsu_respValid", io_lsu_respValid, 0);
    chk("rst_ifu_rdata", io_ifu_rdata, 0);
    chk("rst_lsu_rdata", io_lsu_rdata, 0);
    chk("rst_busy", io_busy, 0);
    chk("rst_timeout", io_timeout, 0);
    chk("rst_stray", io_stray, 0);
  endtask
  // One clock: check every output against the model, then drive memory and masters for this cycle.
  task automatic step();
    logic exp_mreq, rv_now;
    @(posedge clock); #1; cyc++;
    exp_mreq = !in_txn && (cyc - 1 >= idle_from) && (ifu_req || lsu_req);
    chk("mem_reqValid", io_mem_reqValid, exp_mreq);
    if (exp_mreq) begin
      g = (ifu_req && lsu_req) ? 1 - last : (lsu_req ? 1 : 0);
      m_addr  = g != 0 ? lsu_addr : ifu_addr;
      m_wen   = g != 0 ? lsu_wen : 1'b0;
      m_wdata = g != 0 ? lsu_wdata : '0;
      m_wmask = g != 0 ? lsu_wmask : '0;
      m_size  = g != 0 ? lsu_size : 2'b10;
      lat = force_lat == -1 ? int'($urandom_range(1, T + 2)) : force_lat;
      exp_to = lat < 0 || lat > T;
      resp_cyc = cyc + 1 + (exp_to ? T : lat);
      exp_data = exp_to ? ERR : mem_val(m_addr);
      due = lat < 0 ? -1 : cyc + lat;
      iss = cyc;
      in_txn = 1;
    end
    if (in_txn) begin
      chk("mem_addr", io_mem_addr, m_addr);
      chk("mem_wen", io_mem_wen, m_wen);
      chk("mem_wdata", io_mem_wdata, m_wdata);
      chk("mem_wmask", io_mem_wmask, m_wmask);
      chk("mem_size", io_mem_size, m_size);
    end
    chk("busy", io_busy, in_txn);
    rv_now = in_txn && cyc == resp_cyc;
    if (rv_now) begin
      if (g != 0) exp_lsu_rd = exp_data;
      else exp_ifu_rd = exp_data;
    end
    chk("ifu_respValid", io_ifu_respValid, rv_now && g == 0);
    chk("lsu_respValid", io_lsu_respValid, rv_now && g == 1);
    chk("ifu_rdata", io_ifu_rdata, exp_ifu_rd);
    chk("lsu_rdata", io_lsu_rdata, exp_lsu_rd);
    chk("timeout", io_timeout, rv_now && exp_to);
    chk("stray", io_stray, stray_held);
    if (rv_now) begin
      last = g;
      in_txn = 0;
      idle_from = cyc + 1;
    end
    mem_rv = cyc == due;
    stray_held = mem_rv && !(in_txn && cyc > iss && cyc < resp_cyc);
    mem_rdata = mem_rv ? mem_val(m_addr) : $urandom;
    if (auto_m) begin
      if (io_ifu_respValid || !ifu_req) begin
        ifu_req = !drain && $urandom_range(0, 1) == 1;
        ifu_addr = $urandom;
      end
      if (io_lsu_respValid || !lsu_req) begin
        lsu_req = !drain && $urandom_range(0, 1) == 1;
        lsu_addr = $urandom;
        lsu_wen = 1'($urandom);
        lsu_wdata = $urandom;
        lsu_wmask = 4'($urandom);
        lsu_size = 2'($urandom);
      end
    end
  endtask
  task automatic txn_wait(input bit keep, output int who, output int at);
    bit found = 0;
    who = -1;
    at = cyc;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (io_ifu_respValid || io_lsu_respValid) begin
        found = 1;
        who = io_lsu_respValid ? 1 : 0;
        at = cyc;
      end
    end
    chk("resp_seen", found, 1);
    if (found && who == 0) begin
      if (keep) ifu_addr = ifu_addr + 4;
      else ifu_req = 1'b0;
    end
    if (found && who == 1) begin
      if (keep) lsu_addr = lsu_addr + 4;
      else lsu_req = 1'b0;
    end
  endtask
  initial begin
    int who, t, n0, nstray;
    int ts[4];
    do_reset();
    // single fetch, three-cycle latency
    force_lat = 1;
    ifu_req = 1'b1; ifu_addr = 32'h30000000; n0 = cyc;
    txn_wait(0, who, t);
    chk("t1_who", who, 0);
    chk("t1_latency", t - n0, 3);
    chk("t1_rdata", io_ifu_rdata, 32'h00100073);
    // simultaneous requests alternate, IFU first
    do_reset();
    ifu_req = 1'b1; ifu_addr = 32'h30000000;
    lsu_req = 1'b1; lsu_addr = 32'h10000000; lsu_wen = 1'b1;
    lsu_wdata = 32'h41; lsu_wmask = 4'b0001; lsu_size = 2'b00;
    for (int i = 0; i < 4; i++) begin
      txn_wait(1, who, t);
      chk("t2_who", who, i % 2);
    end
    lsu_req = 1'b0;
    txn_wait(0, who, t);
    chk("t2_tail_who", who, 0);
    // timeout then a late reply
    force_lat = T + 3;
    ifu_req = 1'b1; ifu_addr = 32'h30000008;
    txn_wait(0, who, t);
    chk("t3_rdata", io_ifu_rdata, ERR);
    chk("t3_timeout", io_timeout, 1);
    nstray = 0;
    repeat (5) begin
      step();
      nstray += int'(io_stray);
    end
    chk("t3_stray_count", nstray, 1);
    // response on the limit cycle
    force_lat = T;
    lsu_req = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h20000010; lsu_size = 2'b10; lsu_wmask = 4'hf;
    txn_wait(0, who, t);
    chk("t4_timeout", io_timeout, 0);
    chk("t4_rdata", io_lsu_rdata, mem_val(32'h20000010));
    // reset while waiting, then a clean fetch
    force_lat = -2;
    ifu_req = 1'b1; ifu_addr = 32'h30000100;
    repeat (4) step();
    do_reset();
    force_lat = 1;
    ifu_req = 1'b1; ifu_addr = 32'h30000200; n0 = cyc;
    txn_wait(0, who, t);
    chk("t5_latency", t - n0, 3);
    // LSU streaming loads
    lsu_req = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h80000000; lsu_size = 2'b10; lsu_wmask = 4'hf;
    for (int i = 0; i < 4; i++) begin
      txn_wait(1, who, ts[i]);
      chk("t6_who", who, 1);
      if (i > 0) chk("t6_gap", ts[i] - ts[i-1], 4);
    end
    lsu_req = 1'b0;
    // random traffic
    force_lat = -1;
    auto_m = 1;
    repeat (800) step();
    drain = 1;
    repeat (40) step();
    chk("drained", {ifu_req, lsu_req, in_txn}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
